instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 64, giving the number of 32-bit words in the instruction memory.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address.
REQ-003 SHALL have port clk_CPU, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_CPU_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port redirect_valid, input, 1 bit: a taken branch or jump from the datapath.
REQ-006 SHALL have port redirect_target, input, 32 bits: byte address of the redirect.
REQ-007 SHALL have port id_ready, input, 1 bit: the downstream datapath accepts the IF/ID word.
REQ-008 SHALL have port out_valid, output, 1 bit: instr_out and pc_plus4 are valid.
REQ-009 SHALL have port instr_out, output, 32 bits: the fetched instruction word.
REQ-010 SHALL have port pc_plus4, output, 32 bits: fetch address + 4.
REQ-011 SHALL have port fault, output, 1 bit: sticky error flag.
REQ-012 SHALL have port fetch_count, output, 32 bits: count of accepted instructions.
REQ-013 SHALL hold instruction storage in an internal array named instBank, IMEM_DEPTH x 32, loadable by $readmemb through a hierarchical path; no write port.

Function
REQ-014 SHALL implement states IDLE, RUN and HALT.
REQ-015 SHALL go from IDLE to RUN on the first rising edge after reset release, with out_valid=0 in IDLE.
REQ-016 SHALL, in RUN with no redirect and (out_valid==0 or id_ready==1), load instr_out<=instBank[pc[log2(IMEM_DEPTH)+1:2]], pc_plus4<=pc+4, out_valid<=1 and pc<=pc+4.
REQ-017 SHALL, in RUN with out_valid==1 and id_ready==0, hold pc, instr_out, pc_plus4 and out_valid unchanged (no drop, no duplicate).
REQ-018 SHALL give redirect_valid priority over id_ready and stall: next edge out_valid<=0 (flush the wrong-path word) and pc<=redirect_target; fetch resumes the following edge.
REQ-019 SHALL count an accepted transfer whenever out_valid && id_ready at a rising edge, including in the same cycle as a redirect; fetch_count wraps modulo 2^32.
REQ-020 SHALL, on a redirect_target with bits[1:0] != 0, enter HALT with fault<=1 and out_valid<=0.
REQ-021 SHALL, on a pc word index >= IMEM_DEPTH (including 32-bit wrap of pc+4 from 32'hFFFF_FFFC to 0 being out of range beforehand), enter HALT with fault<=1 and out_valid<=0 instead of fetching.
REQ-022 SHALL keep HALT and fault until reset; all inputs are ignored in HALT.
REQ-023 SHALL have a latency of 2 rising edges after reset release to the first out_valid=1, carrying instBank[RESET_PC>>2].

Reset
REQ-024 SHALL, on asynchronous rst_CPU_n=0 at any time including mid-stall or mid-redirect, immediately set state=IDLE, pc=RESET_PC, out_valid=0, instr_out=0, pc_plus4=0, fault=0 and fetch_count=0.
REQ-025 SHALL leave the contents of instBank unaffected by reset.

Structure
REQ-026 SHALL place the state encoding (IDLE/RUN/HALT), the word width of 32 and the default RESET_PC in the shared CPU package/include used by the datapath.
REQ-027 SHALL use one sub-module, pc_register: the PC with async reset and next-pc mux (sequential, redirect, hold).

Verification
REQ-028 SHALL verify: instBank[0..3]=A,B,C,D with id_ready=1 -> out_valid rises at edge 2, instr_out A,B,C,D on consecutive edges, pc_plus4 4,8,12,16, fetch_count 4 after D is accepted.
REQ-029 SHALL verify: id_ready=0 for 3 cycles while B is presented -> B and pc_plus4=8 are held stable, fetch_count is unchanged, and C follows B on the first edge after id_ready=1.
REQ-030 SHALL verify: redirect_valid=1 with target 32'h0000_0020 while C is presented and id_ready=0 -> next edge out_valid=0, then instr_out=instBank[8] and pc_plus4=32'h24.
REQ-031 SHALL verify: redirect target 32'h0000_0006 -> fault=1, out_valid=0, the state stays in HALT for 10 cycles despite id_ready/redirect activity.
REQ-032 SHALL verify: sequential fetch to word 63 with IMEM_DEPTH=64 -> instBank[63] is delivered, then fault=1 and out_valid=0 (no access at index 64).
REQ-033 SHALL verify: rst_CPU_n pulsed low between clock edges during a stall -> all outputs clear immediately, and after release instBank[0] reappears at edge 2.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared CPU constants: word width, reset PC, fetch FSM and PC-mux encodings
package instruction_fetch_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  localparam logic [1:0] PC_HOLD  = 2'd0;
  localparam logic [1:0] PC_SEQ   = 2'd1;
  localparam logic [1:0] PC_REDIR = 2'd2;
endpackage

// File: rtl/instruction_fetch_pc_register.sv
// rtl/instruction_fetch_pc_register.sv - program counter with async reset and hold/sequential/redirect mux
module pc_register
  import instruction_fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        sel,
  input  logic [WORD_W-1:0] target,
  output logic [WORD_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      case (sel)
        PC_SEQ:   pc <= pc + 32'd4;
        PC_REDIR: pc <= target;
        default:  pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: ROM read, IF/ID handshake, redirect flush, sticky fault halt
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                IMEM_DEPTH = 64,
  parameter logic [WORD_W-1:0] RESET_PC   = DEFAULT_RESET_PC
) (
  input  logic              clk_CPU,
  input  logic              rst_CPU_n,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_target,
  input  logic              id_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] instr_out,
  output logic [WORD_W-1:0] pc_plus4,
  output logic              fault,
  output logic [WORD_W-1:0] fetch_count
);

  localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

  logic [WORD_W-1:0] instBank [0:IMEM_DEPTH-1];

  logic [1:0]        state;
  logic [1:0]        pc_sel;
  logic [WORD_W-1:0] pc;
  logic              in_range;
  logic              misaligned;
  logic              advance;

  // Word index is checked on the full pc, so a wrapped or huge pc can never alias into the ROM.
  assign in_range   = {2'b00, pc[WORD_W-1:2]} < 32'(IMEM_DEPTH);
  assign misaligned = redirect_target[1:0] != 2'b00;
  assign advance    = !out_valid || id_ready;

  always_comb begin
    pc_sel = PC_HOLD;
    if (state == RUN) begin
      if (redirect_valid) begin
        if (!misaligned) pc_sel = PC_REDIR;
      end else if (advance && in_range) begin
        pc_sel = PC_SEQ;
      end
    end
  end

  pc_register #(.RESET_PC(RESET_PC)) u_pc_register (
    .clk    (clk_CPU),
    .rst_n  (rst_CPU_n),
    .sel    (pc_sel),
    .target (redirect_target),
    .pc     (pc)
  );

  always_ff @(posedge clk_CPU or negedge rst_CPU_n) begin
    if (!rst_CPU_n) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      instr_out   <= '0;
      pc_plus4    <= '0;
      fault       <= 1'b0;
      fetch_count <= '0;
    end else begin
      // The word on the bus is consumed even if a redirect flushes the stage this same edge.
      if (out_valid && id_ready) fetch_count <= fetch_count + 32'd1;

      case (state)
        IDLE: state <= RUN;
        RUN: begin
          if (redirect_valid) begin
            out_valid <= 1'b0;
            if (misaligned) begin
              state <= HALT;
              fault <= 1'b1;
            end
          end else if (advance) begin
            if (in_range) begin
              instr_out <= instBank[pc[AW+1:2]];
              pc_plus4  <= pc + 32'd4;
              out_valid <= 1'b1;
            end else begin
              state     <= HALT;
              fault     <= 1'b1;
              out_valid <= 1'b0;
            end
          end
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch with directed and random phases
module tb_instruction_fetch;

  localparam int DEPTH = 64;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  logic        clk_CPU = 1'b0;
  logic        rst_CPU_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        id_ready = 1'b0;
  logic        out_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_plus4;
  logic        fault;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:DEPTH-1];
  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          mcount = 0;

  instruction_fetch #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_CPU         (clk_CPU),
    .rst_CPU_n       (rst_CPU_n),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_ready        (id_ready),
    .out_valid       (out_valid),
    .instr_out       (instr_out),
    .pc_plus4        (pc_plus4),
    .fault           (fault),
    .fetch_count     (fetch_count)
  );

  always #5 clk_CPU = ~clk_CPU;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_CPU);
    #1;
  endtask

  // Expected delivery stream: consecutive words from addr until the end of the ROM.
  task automatic push_stream(input logic [31:0] addr);
    logic [31:0] a;
    a = addr;
    while ((a >> 2) < DEPTH) begin
      q.push_back('{instr: mem[a >> 2], pc4: a + 32'd4});
      a = a + 32'd4;
    end
  endtask

  task automatic do_reset();
    rst_CPU_n = 1'b0;
    redirect_valid = 1'b0;
    id_ready = 1'b0;
    q.delete();
    mcount = 0;
    repeat (2) tick();
    push_stream(32'h0);
    rst_CPU_n = 1'b1;
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_target = target;
    tick();
    redirect_valid = 1'b0;
    q.delete();
    if (target[1:0] == 2'b00) push_stream(target);
  endtask

  // Monitor: every accepted transfer must match the head of the expected stream.
  always @(negedge clk_CPU) begin
    if (rst_CPU_n && out_valid && id_ready) begin
      check("count_at_accept", fetch_count, 32'(mcount));
      mcount++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual=%h expected=none", instr_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sb_instr", instr_out, e.instr);
        check("sb_pc_plus4", pc_plus4, e.pc4);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int since;
    logic [31:0] t;

    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[0] = 32'hA000_000A;
    mem[1] = 32'hB000_000B;
    mem[2] = 32'hC000_000C;
    mem[3] = 32'hD000_000D;
    for (int i = 0; i < DEPTH; i++) dut.instBank[i] = mem[i];

    // Reset values and in-order delivery of A..D.
    rst_CPU_n = 1'b0;
    #1;
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_fault", {31'd0, fault}, 32'd0);
    check("reset_count", fetch_count, 32'd0);
    do_reset();
    id_ready = 1'b1;
    tick();
    check("edge1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("edge2_valid", {31'd0, out_valid}, 32'd1);
    check("edge2_instr", instr_out, mem[0]);
    check("edge2_pc4", pc_plus4, 32'd4);
    tick();
    check("edge3_instr", instr_out, mem[1]);
    check("edge3_pc4", pc_plus4, 32'd8);
    tick();
    check("edge4_pc4", pc_plus4, 32'd12);
    tick();
    check("edge5_instr", instr_out, mem[3]);
    check("edge5_pc4", pc_plus4, 32'd16);
    tick();
    check("count_after_d", fetch_count, 32'd4);

    // Stall on B, then release, then redirect while C is stalled.
    do_reset();
    id_ready = 1'b1;
    repeat (3) tick();
    id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_instr", instr_out, mem[1]);
      check("stall_pc4", pc_plus4, 32'd8);
      check("stall_count", fetch_count, 32'd1);
    end
    id_ready = 1'b1;
    tick();
    check("after_stall_instr", instr_out, mem[2]);
    check("after_stall_pc4", pc_plus4, 32'd12);
    id_ready = 1'b0;
    redirect_to(32'h0000_0020);
    check("redir_flush_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("redir_valid", {31'd0, out_valid}, 32'd1);
    check("redir_instr", instr_out, mem[8]);
    check("redir_pc4", pc_plus4, 32'h24);
    check("redir_count", fetch_count, 32'd2);

    // Misaligned redirect halts permanently.
    redirect_to(32'h0000_0006);
    for (int k = 0; k < 10; k++) begin
      check("halt_fault", {31'd0, fault}, 32'd1);
      check("halt_valid", {31'd0, out_valid}, 32'd0);
      id_ready = 1'($urandom);
      redirect_valid = 1'($urandom);
      redirect_target = $urandom_range(0, 40) << 2;
      tick();
    end
    redirect_valid = 1'b0;
    check("halt_count", fetch_count, 32'd2);

    // Run off the end of the ROM.
    do_reset();
    id_ready = 1'b1;
    n = 0;
    while (!fault && n < 200) begin
      tick();
      n++;
    end
    check("end_fault", {31'd0, fault}, 32'd1);
    check("end_valid", {31'd0, out_valid}, 32'd0);
    check("end_count", fetch_count, 32'd64);
    check("end_queue_left", 32'(q.size()), 32'd0);
    check("end_edges", 32'(n), 32'd66);

    // Asynchronous reset during a stall.
    do_reset();
    id_ready = 1'b1;
    repeat (3) tick();
    id_ready = 1'b0;
    repeat (2) tick();
    #2;
    rst_CPU_n = 1'b0;
    #1;
    check("async_valid", {31'd0, out_valid}, 32'd0);
    check("async_instr", instr_out, 32'd0);
    check("async_pc4", pc_plus4, 32'd0);
    check("async_fault", {31'd0, fault}, 32'd0);
    check("async_count", fetch_count, 32'd0);
    q.delete();
    mcount = 0;
    push_stream(32'h0);
    @(posedge clk_CPU);
    #2;
    rst_CPU_n = 1'b1;
    id_ready = 1'b1;
    tick();
    check("async_edge1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("async_edge2_valid", {31'd0, out_valid}, 32'd1);
    check("async_edge2_instr", instr_out, mem[0]);

    // Random backpressure and aligned redirects.
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom;
      dut.instBank[i] = mem[i];
    end
    do_reset();
    since = 0;
    for (int i = 0; i < 400; i++) begin
      id_ready = ($urandom % 4) != 0;
      if (i >= 2 && (since > 20 || ($urandom % 16) == 0)) begin
        t = $urandom_range(0, 40) << 2;
        redirect_to(t);
        since = 0;
      end else begin
        tick();
        since++;
      end
    end
    check("random_fault", {31'd0, fault}, 32'd0);
    check("random_count", fetch_count, 32'(mcount));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
